// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - round-robin scheduler sharing one fixed-latency divider among requesters
module divider_scheduler #(
    parameter int DATA_LEN = 32,
    parameter int NUM_REQ  = 4,
    parameter int LATENCY  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [NUM_REQ*DATA_LEN-1:0] rsp_result,
    input  logic                        flush_req,
    output logic                        busy,
    output logic                        div_reset,
    output logic [DATA_LEN-1:0]         div_a,
    output logic [DATA_LEN-1:0]         div_b,
    input  logic [DATA_LEN-1:0]         div_result
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(LATENCY - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [LATENCY:0]     tag_vld_q, tag_vld_d;
    logic [PW-1:0]        tag_id_q [LATENCY+1];
    logic [PW-1:0]        tag_id_d [LATENCY+1];
    logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [DATA_LEN-1:0]  rsp_data_q [NUM_REQ];
    logic [DATA_LEN-1:0]  rsp_data_d [NUM_REQ];
    logic [DATA_LEN-1:0]  div_a_q, div_a_d;
    logic [DATA_LEN-1:0]  div_b_q, div_b_d;

    logic [NUM_REQ-1:0]   in_flight;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [PW-1:0]        grant_id;
    logic                 accept;
    logic                 can_issue;
    logic                 flush_take;
    logic                 capture;
    logic [PW-1:0]        cap_id;
    int                   arb_idx;
    int                   rr_next;

    assign flush_take = (state_q == ST_RUN) && flush_req;
    assign can_issue  = (state_q == ST_RUN) && !flush_req;
    // A tag leaving the pipe on the flush-entry edge belongs to an aborted op.
    assign capture    = tag_vld_q[LATENCY] && !flush_take;
    assign cap_id     = tag_id_q[LATENCY];

    // A requester is busy while any tag stage carries its id.
    always_comb begin
        in_flight = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int s = 0; s <= LATENCY; s++) begin
                if (tag_vld_q[s] && (tag_id_q[s] == PW'(r))) begin
                    in_flight[r] = 1'b1;
                end
            end
        end
        eligible = req_valid & ~in_flight & ~rsp_vld_q;
    end

    // Round-robin pick: scan from rr_ptr_q upward, wrapping, first eligible wins.
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        accept   = 1'b0;
        arb_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (can_issue && !accept && eligible[r] && (r == arb_idx)) begin
                    accept      = 1'b1;
                    grant_oh[r] = 1'b1;
                    grant_id    = PW'(r);
                end
            end
        end
    end

    // Pointer moves to the index after the last granted requester.
    always_comb begin
        rr_next = int'(grant_id) + 1;
        if (rr_next >= NUM_REQ) begin
            rr_next = 0;
        end
        rr_ptr_d = accept ? PW'(rr_next) : rr_ptr_q;
    end

    // Operands are presented for exactly the cycle after the accept, zero otherwise.
    always_comb begin
        div_a_d = '0;
        div_b_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_oh[r]) begin
                div_a_d = req_a[r*DATA_LEN +: DATA_LEN];
                div_b_d = req_b[r*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Tag pipe mirrors the divider latency; a flush wipes every stage.
    always_comb begin
        tag_vld_d[0] = accept;
        tag_id_d[0]  = grant_id;
        for (int s = 1; s <= LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
        if (flush_take) begin
            tag_vld_d = '0;
        end
    end

    // Result slots: drain on consume, fill when the matching tag emerges.
    always_comb begin
        rsp_vld_d = rsp_vld_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_data_d[r] = rsp_data_q[r];
            if (rsp_vld_q[r] && rsp_ready[r]) begin
                rsp_vld_d[r] = 1'b0;
            end
            if (capture && (cap_id == PW'(r))) begin
                rsp_vld_d[r]  = 1'b1;
                rsp_data_d[r] = div_result;
            end
        end
    end

    // RUN/FLUSH control: flush holds the divider in reset for LATENCY cycles.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // All state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            rr_ptr_q    <= '0;
            tag_vld_q   <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_vld_q   <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                rsp_data_q[r] <= '0;
            end
            div_a_q     <= '0;
            div_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
        end
    end

    // Pack slot contents onto the flat result bus.
    always_comb begin
        rsp_result = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_result[r*DATA_LEN +: DATA_LEN] = rsp_data_q[r];
        end
    end

    assign req_ready = reset ? '0 : grant_oh;
    assign rsp_valid = rsp_vld_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign busy      = (|tag_vld_q) || (state_q == ST_FLUSH);
    assign div_reset = reset || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - scoreboard bench for divider_scheduler
module tb_divider_scheduler;
    localparam int DL  = 32;
    localparam int NR  = 4;
    localparam int LAT = 6;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DL-1:0]  req_a;
    logic [NR*DL-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [NR*DL-1:0]  rsp_result;
    logic              flush_req;
    logic              busy;
    logic              div_reset;
    logic [DL-1:0]     div_a;
    logic [DL-1:0]     div_b;
    logic [DL-1:0]     div_result;

    divider_scheduler #(.DATA_LEN(DL), .NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .flush_req  (flush_req),
        .busy       (busy),
        .div_reset  (div_reset),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: LAT-stage pipe, quotient of all-ones for a zero divisor.
    logic [DL-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (div_reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= (div_b == '0) ? {DL{1'b1}} : div_a / div_b;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign div_result = pipe[LAT-1];

    int errors = 0;
    int checks = 0;

    int          q_id[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    logic [NR-1:0] pend;
    logic [NR-1:0] rdy;
    logic [NR-1:0] acc_mask;
    logic [31:0]   pa [NR];
    logic [31:0]   pb [NR];
    logic [31:0]   pq [NR];
    logic          flush_now;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        pend[r] = 1'b1;
        pa[r]   = a;
        pb[r]   = b;
        pq[r]   = q;
    endtask

    // One cycle: drive at negedge, then record accepts and their expected results.
    task automatic step();
        @(negedge clk);
        req_valid = pend;
        req_a     = {pa[3], pa[2], pa[1], pa[0]};
        req_b     = {pb[3], pb[2], pb[1], pb[0]};
        rsp_ready = rdy;
        flush_req = flush_now;
        flush_now = 1'b0;
        #1;
        acc_mask = req_valid & req_ready;
        for (int r = 0; r < NR; r++) begin
            if (acc_mask[r]) begin
                q_id.push_back(r);
                q_data.push_back(pq[r]);
                q_cyc.push_back(cyc + LAT + 2);
                pend[r] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drop_from(input int c, output int n);
        n = 0;
        for (int i = q_id.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] >= c) begin
                q_id.delete(i);
                q_data.delete(i);
                q_cyc.delete(i);
                n++;
            end
        end
    endtask

    // Monitor: every rising rsp_valid must match the oldest expectation for that requester.
    initial begin
        logic [NR-1:0] prev;
        int idx;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (rsp_valid[r] && !prev[r]) begin
                    idx = -1;
                    for (int i = 0; i < q_id.size(); i++) begin
                        if (idx < 0 && q_id[i] == r) idx = i;
                    end
                    if (idx < 0) begin
                        chk($sformatf("rsp%0d_unexpected_valid", r), 64'(rsp_valid[r]), 64'd0);
                    end else begin
                        chk($sformatf("rsp%0d_data", r), 64'(rsp_result[r*DL +: DL]), 64'(q_data[idx]));
                        chk($sformatf("rsp%0d_cycle", r), 64'(cyc), 64'(q_cyc[idx]));
                        q_id.delete(idx);
                        q_data.delete(idx);
                        q_cyc.delete(idx);
                    end
                end
            end
            prev = rsp_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int got;
        rst       = 1'b0;
        pend      = '0;
        rdy       = '1;
        flush_now = 1'b0;
        acc_mask  = '0;
        for (int r = 0; r < NR; r++) begin
            pa[r] = '0; pb[r] = '0; pq[r] = '0;
        end
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        flush_req = 1'b0;

        // Reset state, with requests pending to show req_ready is gated.
        #1 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_div_reset", 64'(div_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_div_a", 64'(div_a), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result[63:0]), 64'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;

        // Contention: all four at once, grants 0,1,2,3 on consecutive cycles.
        set_op(0, 1000, 10, 100);
        set_op(1, 81, 9, 9);
        set_op(2, 7, 2, 3);
        set_op(3, 5, 0, 32'hFFFF_FFFF);
        for (int k = 0; k < NR; k++) begin
            step();
            chk($sformatf("cont_grant%0d", k), 64'(acc_mask), 64'(1 << k));
        end
        idle(12);

        // Single op: 100/7 with one-cycle operand presentation.
        set_op(0, 100, 7, 14);
        step();
        chk("single_accept", 64'(acc_mask), 64'b0001);
        step();
        chk("single_div_a", 64'(div_a), 64'd100);
        chk("single_div_b", 64'(div_b), 64'd7);
        step();
        chk("single_div_a_clear", 64'(div_a), 64'd0);
        chk("single_div_b_clear", 64'(div_b), 64'd0);
        idle(10);

        // Backpressure on requester 2.
        rdy[2] = 1'b0;
        set_op(2, 50, 5, 10);
        step();
        chk("bp_accept", 64'(acc_mask), 64'b0100);
        idle(9);
        set_op(2, 77, 7, 11);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_blocked%0d", k), 64'(req_ready[2]), 64'd0);
        end
        rdy[2] = 1'b1;
        step();
        chk("bp_drain_cycle", 64'(req_ready[2]), 64'd0);
        step();
        chk("bp_reaccept", 64'(acc_mask[2]), 64'd1);
        idle(10);

        // Flush two cycles after accepting 9/3 for requester 1; a second pulse mid-flush is ignored.
        set_op(1, 9, 3, 3);
        step();
        chk("flush_accept", 64'(acc_mask), 64'b0010);
        step();
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush_now = 1'b1;
        step();
        drop_from(cyc + 1, n);
        chk("flush_dropped", 64'(n), 64'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) flush_now = 1'b1;
            step();
            if (div_reset) cnt++;
        end
        chk("flush_div_reset_cycles", 64'(cnt), 64'd6);
        chk("flush_busy_after", 64'(busy), 64'd0);

        // Flush colliding with a request from requester 3.
        set_op(3, 200, 8, 25);
        flush_now = 1'b1;
        step();
        chk("coll_no_ready", 64'(req_ready), 64'd0);
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (acc_mask[3]) begin
                got = k;
                break;
            end
        end
        chk("coll_accept_step", 64'(got), 64'd7);
        idle(10);

        // Reset mid-op with a held result and one op in flight.
        rdy[1] = 1'b0;
        set_op(1, 10, 2, 5);
        step();
        chk("rmid_hold_accept", 64'(acc_mask), 64'b0010);
        idle(9);
        set_op(0, 64, 4, 16);
        step();
        chk("rmid_accept", 64'(acc_mask), 64'b0001);
        idle(3);
        #1 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        drop_from(0, n);
        chk("rmid_dropped", 64'(n), 64'd1);
        chk("rmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rmid_rsp_result", 64'(rsp_result[63:0]), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_div_reset", 64'(div_reset), 64'd1);
        chk("rmid_req_ready", 64'(req_ready), 64'd0);
        chk("rmid_div_a", 64'(div_a), 64'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        pend      = '0;
        rdy       = '1;
        idle(15);

        chk("sb_empty", 64'(q_id.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divider_scheduler.md
DIVIDER_SCHEDULER -- requirements
Module: divider_scheduler

Interface
REQ-001 Parameter DATA_LEN, default 32, is the operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4, is the number of requesters, range 2..8.
REQ-003 Parameter LATENCY, default 6, is the fixed divider latency in cycles from registered operands to a valid div_result.
REQ-004 clk  in  1  is the single clock; all state changes on the rising edge.
REQ-005 reset  in  1  is the asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  is the per-requester operation request.
REQ-007 req_ready  out  NUM_REQ  is the per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-008 req_a  in  NUM_REQ*DATA_LEN  carries the dividends; requester i uses bits [i*DATA_LEN +: DATA_LEN].
REQ-009 req_b  in  NUM_REQ*DATA_LEN  carries the divisors, packed as req_a.
REQ-010 rsp_valid  out  NUM_REQ  is high while requester i's result slot is full.
REQ-011 rsp_ready  in  NUM_REQ  is the requester's result consume strobe.
REQ-012 rsp_result  out  NUM_REQ*DATA_LEN  carries the per-requester quotient, packed as req_a.
REQ-013 flush_req  in  1  is a single-cycle pulse that aborts in-flight operations.
REQ-014 busy  out  1  is high while any operation is in flight or a flush is in progress.
REQ-015 div_reset  out  1  drives the divider reset.
REQ-016 div_a and div_b  out  DATA_LEN each  drive the divider operands.
REQ-017 div_result  in  DATA_LEN  is the divider quotient.

Function
REQ-018 The FSM SHALL have two states: RUN and FLUSH.
REQ-019 Requester i SHALL be eligible when req_valid[i] is high, no operation of i is in flight, and rsp slot i is empty, which limits each requester to one outstanding operation.
REQ-020 In RUN, exactly one eligible requester per cycle SHALL receive req_ready.
  - Arbitration is round-robin, starting at the index after the last granted requester.
  - The pointer resets to index 0, so requester 0 has highest priority after reset.
REQ-021 req_ready SHALL be all-zero in FLUSH, and in any cycle where flush_req is high.
REQ-022 On an accept at edge E0, div_a and div_b SHALL take the granted operands for exactly one cycle; at all other times they SHALL be zero.
REQ-023 A tag shift register of LATENCY+1 stages, each holding a valid bit and a requester id, SHALL track every issued operation.
REQ-024 Result capture:
  - The issued operation's div_result is captured into rsp slot id at edge E0+LATENCY+1.
  - rsp_valid[id] is high from that edge onward.
REQ-025 A full rsp slot SHALL hold its value until rsp_valid and rsp_ready are both high at an edge; the slot then empties.
REQ-026 A slot that empties at edge E SHALL make its requester eligible in the cycle after E.
REQ-027 Sustained throughput SHALL be one accept per cycle when at least one requester is eligible.
REQ-028 Division by zero and other operand values SHALL be passed through unchanged; the result is whatever the divider returns.
REQ-029 On flush_req in RUN, the FSM SHALL enter FLUSH for exactly LATENCY cycles and then return to RUN.
  - All tag stages are invalidated on entry.
  - Results already captured in rsp slots are retained.
REQ-030 flush_req received in FLUSH SHALL be ignored; the flush countdown is not restarted.
REQ-031 If flush_req and an accept candidate occur in the same cycle, flush SHALL win and no operation is accepted.
REQ-032 If a tag emerges on the edge that enters FLUSH, it SHALL be discarded and its slot is not written.
REQ-033 div_reset SHALL equal reset OR (state == FLUSH).
REQ-034 busy SHALL equal (any tag stage valid) OR (state == FLUSH).

Reset
REQ-035 Asserting reset SHALL immediately set the following:
  - state = RUN; all tag valid bits = 0; all rsp slots empty; rsp_result = 0.
  - req_ready = 0; div_a = 0; div_b = 0; busy = 0; round-robin pointer = 0; div_reset = 1.
REQ-036 Assertion of reset mid-operation SHALL discard all in-flight operations and held results without producing any rsp_valid.
REQ-037 Normal operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-038 Single op: requester 0 sends a=100, b=7 -> div_a=100 and div_b=7 for one cycle; rsp_valid[0] at E0+7; rsp_result[0]=14.
REQ-039 Contention: all four requesters valid at once -> grants to 0, 1, 2, 3 on consecutive cycles; each rsp_valid follows its own accept by 7 cycles.
REQ-040 Backpressure: requester 2 holds rsp_ready=0 with its result 50/5=10 pending -> req_ready[2] stays 0 until the slot drains; then a new op is accepted one cycle later.
REQ-041 Flush: flush_req two cycles after accepting 9/3 for requester 1 -> div_reset high for 6 cycles; no rsp_valid[1]; busy low after the flush.
REQ-042 Flush collision: flush_req in the same cycle as req_valid[3] -> no accept; requester 3 is accepted on the first RUN cycle after the flush.
REQ-043 Reset mid-op: reset asserted 3 cycles after an accept -> all outputs at reset values immediately; no response appears afterward.
